// File: rtl/axi_block_writer.sv
// AXI4 write-burst master: loads one cache line and writes it out as a single INCR burst, low word first.
// Optional B-response error flag enabled by defining AXI_WRITER_BRESP_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for i_start; o_done pulses here after a completed burst
// ADDR  | presenting the burst address on AW
// DATA  | shifting the line out on W, one word per handshake
// RESP  | waiting for the write response on B
module axi_block_writer #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BLOCK_WIDTH    = 512
) (
  input  logic                        i_clk,
  input  logic                        i_arst,
  input  logic                        i_start,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
  input  logic [BLOCK_WIDTH-1:0]      i_data_block,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic                        o_awvalid,
  output logic [AXI_ADDR_WIDTH-1:0]   o_awaddr,
  output logic [7:0]                  o_awlen,
  output logic [2:0]                  o_awsize,
  output logic [1:0]                  o_awburst,
  input  logic                        i_awready,
  output logic                        o_wvalid,
  output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
  output logic                        o_wlast,
  input  logic                        i_wready,
  input  logic                        i_bvalid,
  input  logic [1:0]                  i_bresp,
  output logic                        o_bready
);

  localparam int BEATS    = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ADDR_LSB = $clog2(BLOCK_WIDTH / 8);
  localparam int SIZE     = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK =
    ~((AXI_ADDR_WIDTH'(1) << ADDR_LSB) - AXI_ADDR_WIDTH'(1));

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                    state_q;
  logic [BLOCK_WIDTH-1:0]    buf_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      bready_q;
  logic                      done_q;
`ifdef AXI_WRITER_BRESP_CHECK_EN
  logic                      error_q;
`endif

  // Valids are only ever cleared on their own handshake, so payloads stay stable while stalled.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef AXI_WRITER_BRESP_CHECK_EN
      error_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            buf_q     <= i_data_block;
            addr_q    <= i_addr & ADDR_MASK;
            awvalid_q <= 1'b1;
            state_q   <= ADDR;
`ifdef AXI_WRITER_BRESP_CHECK_EN
            error_q   <= 1'b0;
`endif
          end
        end
        ADDR: begin
          if (i_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (i_wready) begin
            buf_q <= buf_q >> AXI_DATA_WIDTH;
            if (cnt_q == LAST_BEAT) begin
              cnt_q    <= '0;
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= RESP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        RESP: begin
          if (i_bvalid) begin
            bready_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
`ifdef AXI_WRITER_BRESP_CHECK_EN
            if (i_bresp != 2'b00) error_q <= 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy    = (state_q != IDLE);
  assign o_done    = done_q;
  assign o_awvalid = awvalid_q;
  assign o_awaddr  = addr_q;
  // Fixed AW fields are gated so that every output reads zero out of reset.
  assign o_awlen   = awvalid_q ? 8'(BEATS - 1) : 8'd0;
  assign o_awsize  = awvalid_q ? 3'(SIZE) : 3'd0;
  assign o_awburst = awvalid_q ? 2'b01 : 2'b00;
  assign o_wvalid  = wvalid_q;
  assign o_wdata   = buf_q[AXI_DATA_WIDTH-1:0];
  assign o_wstrb   = {(AXI_DATA_WIDTH/8){wvalid_q}};
  assign o_wlast   = wvalid_q && (cnt_q == LAST_BEAT);
  assign o_bready  = bready_q;

`ifdef AXI_WRITER_BRESP_CHECK_EN
  assign o_error = error_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^i_bresp;
  assign o_error      = 1'b0;
`endif

endmodule

// File: tb/tb_axi_block_writer.sv
// Self-checking bench for axi_block_writer: a cycle driver plays the slave and records what it
// saw; each test compares those records against a line-level model of the burst.
module tb_axi_block_writer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = 512;
  localparam int BEATS = BW / DW;

  typedef logic [DW-1:0] beat_q_t[$];

  logic              i_clk = 1'b0;
  logic              i_arst;
  logic              i_start;
  logic [AW-1:0]     i_addr;
  logic [BW-1:0]     i_data_block;
  logic              o_busy, o_done, o_error;
  logic              o_awvalid;
  logic [AW-1:0]     o_awaddr;
  logic [7:0]        o_awlen;
  logic [2:0]        o_awsize;
  logic [1:0]        o_awburst;
  logic              i_awready;
  logic              o_wvalid;
  logic [DW-1:0]     o_wdata;
  logic [DW/8-1:0]   o_wstrb;
  logic              o_wlast;
  logic              i_wready;
  logic              i_bvalid;
  logic [1:0]        i_bresp;
  logic              o_bready;

  axi_block_writer #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .BLOCK_WIDTH(BW)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_start(i_start), .i_addr(i_addr),
    .i_data_block(i_data_block), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .i_awready(i_awready), .o_wvalid(o_wvalid), .o_wdata(o_wdata),
    .o_wstrb(o_wstrb), .o_wlast(o_wlast), .i_wready(i_wready), .i_bvalid(i_bvalid),
    .i_bresp(i_bresp), .o_bready(o_bready)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations recorded by drive_burst
  logic [DW-1:0] beats_q[$];
  logic          lasts_q[$];
  logic [AW-1:0] cap_awaddr;
  logic [7:0]    cap_awlen;
  logic [2:0]    cap_awsize;
  logic [1:0]    cap_awburst;
  int            aw_hs, b_hs, done_cyc, stab_err, w_before_aw, strb_err;
  logic          first_awvalid, err_c1;
  logic [5:0]    rst_snap;

  `ifdef AXI_WRITER_BRESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
  `else
  localparam logic EXP_ERR = 1'b0;
  `endif

  // Reference model: a line is sent as consecutive DW-bit words from bit 0 upward,
  // to the line-aligned address.
  function automatic beat_q_t model_beats(input logic [BW-1:0] blk);
    beat_q_t q;
    for (int i = 0; i < BEATS; i++) q.push_back(blk[i*DW +: DW]);
    return q;
  endfunction

  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] a);
    return a - (a % AW'(BW / 8));
  endfunction

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    for (int i = 0; i < BEATS; i++) b[i*DW +: DW] = $urandom();
    return b;
  endfunction

  // Called at a negedge; raises i_start for the current cycle and then acts as the AXI slave.
  // stall_mode: 0 wready always high, 1 high on odd cycles only, 2 random.
  task automatic drive_burst(input logic [AW-1:0] addr, input logic [BW-1:0] blk,
                             input int aw_wait, input int stall_mode, input int b_wait,
                             input bit b_early, input int mid_start_at, input int abort_after,
                             input logic [1:0] resp);
    int cyc, aw_seen, b_seen;
    bit aw_pend, w_pend, early_done, aw_done, mid_done;
    logic [AW-1:0] p_awaddr;
    logic [DW-1:0] p_wdata;
    logic p_wlast;
    beats_q.delete(); lasts_q.delete();
    aw_hs = 0; b_hs = 0; done_cyc = -1; stab_err = 0; w_before_aw = 0; strb_err = 0;
    rst_snap = '1; first_awvalid = 1'b0; err_c1 = 1'bx;
    aw_seen = 0; b_seen = 0; aw_pend = 0; w_pend = 0; early_done = 0; aw_done = 0; mid_done = 0;
    p_awaddr = '0; p_wdata = '0; p_wlast = 1'b0;
    i_start = 1'b1; i_addr = addr; i_data_block = blk;
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
    @(negedge i_clk);
    cyc = 1;
    while (cyc < 400) begin
      i_start = 1'b0;
      if (cyc == 1) begin
        first_awvalid = o_awvalid;
        err_c1 = o_error;
      end
      if (o_done) begin
        done_cyc = cyc;
        break;
      end
      if (abort_after > 0 && beats_q.size() == abort_after) begin
        i_arst = 1'b1; i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0;
        #1;
        rst_snap = {o_busy, o_awvalid, o_wvalid, o_bready, o_done, o_wlast};
        break;
      end
      if (aw_pend && (!o_awvalid || o_awaddr !== p_awaddr)) stab_err++;
      if (w_pend && (!o_wvalid || o_wdata !== p_wdata || o_wlast !== p_wlast)) stab_err++;
      if (o_wvalid && !aw_done) w_before_aw++;
      if (o_wvalid && o_wstrb !== '1) strb_err++;
      if (mid_start_at > 0 && beats_q.size() == mid_start_at && o_wvalid && !mid_done) begin
        i_start = 1'b1; i_addr = ~addr; i_data_block = ~blk; mid_done = 1;
      end
      i_awready = o_awvalid && (aw_seen >= aw_wait);
      if (o_awvalid) aw_seen++;
      case (stall_mode)
        1:       i_wready = ((cyc % 2) == 1);
        2:       i_wready = ($urandom_range(0, 2) != 0);
        default: i_wready = 1'b1;
      endcase
      i_bvalid = 1'b0; i_bresp = 2'b00;
      if (o_bready) begin
        i_bvalid = (b_seen >= b_wait); i_bresp = resp; b_seen++;
      end else if (b_early && o_wvalid && !early_done) begin
        i_bvalid = 1'b1; i_bresp = 2'b10; early_done = 1;
      end
      if (o_awvalid && i_awready) begin
        cap_awaddr = o_awaddr; cap_awlen = o_awlen; cap_awsize = o_awsize; cap_awburst = o_awburst;
        aw_hs++; aw_done = 1;
      end
      if (o_wvalid && i_wready) begin
        beats_q.push_back(o_wdata); lasts_q.push_back(o_wlast);
      end
      if (o_bready && i_bvalid) b_hs++;
      aw_pend = o_awvalid && !i_awready; p_awaddr = o_awaddr;
      w_pend = o_wvalid && !i_wready; p_wdata = o_wdata; p_wlast = o_wlast;
      @(negedge i_clk);
      cyc++;
    end
    i_start = 1'b0; i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({o_busy, o_awvalid, o_wvalid, o_bready, o_done, o_error, o_wlast} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got busy/awv/wv/br/done/err/last=%b, expected 0000000",
               {o_busy, o_awvalid, o_wvalid, o_bready, o_done, o_error, o_wlast});
    end
    n_cmp++;
    if (o_awaddr !== '0 || o_wdata !== '0) begin
      n_bad++;
      $display("FAIL reset_payload: got awaddr=%h wdata=%h, expected 0/0", o_awaddr, o_wdata);
    end
    i_arst = 1'b0;
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if (o_busy !== 1'b0 || o_awvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b awvalid=%b, expected 0/0", o_busy, o_awvalid);
    end
  endtask

  task automatic test_basic();
    logic [BW-1:0] blk;
    beat_q_t exp;
    for (int i = 0; i < BEATS; i++) blk[i*DW +: DW] = DW'(i);
    exp = model_beats(blk);
    drive_burst(32'h1234_5678, blk, 0, 0, 0, 0, 0, 0, 2'b00);
    n_cmp++;
    if (cap_awaddr !== model_addr(32'h1234_5678) || cap_awaddr !== 32'h1234_5640) begin
      n_bad++;
      $display("FAIL basic_awaddr: got %h, expected %h", cap_awaddr, 32'h1234_5640);
    end
    n_cmp++;
    if (cap_awlen !== 8'(BEATS - 1) || cap_awsize !== 3'd2 || cap_awburst !== 2'b01) begin
      n_bad++;
      $display("FAIL basic_awfields: got len=%0d size=%0d burst=%0d, expected 15/2/1",
               cap_awlen, cap_awsize, cap_awburst);
    end
    n_cmp++;
    if (beats_q.size() !== exp.size()) begin
      n_bad++;
      $display("FAIL basic_beat_count: got %0d, expected %0d", beats_q.size(), exp.size());
    end
    foreach (exp[i]) begin
      n_cmp++;
      if (i >= beats_q.size() || beats_q[i] !== exp[i] || lasts_q[i] !== (i == exp.size() - 1)) begin
        n_bad++;
        $display("FAIL basic_beat[%0d]: got %h last=%b, expected %h last=%b",
                 i, beats_q[i], lasts_q[i], exp[i], (i == exp.size() - 1));
      end
    end
    n_cmp++;
    if (done_cyc !== BEATS + 3) begin
      n_bad++;
      $display("FAIL basic_latency: got done at cycle %0d, expected %0d", done_cyc, BEATS + 3);
    end
    n_cmp++;
    if (strb_err !== 0 || b_hs !== 1) begin
      n_bad++;
      $display("FAIL basic_strb_b: got strb_err=%0d b_hs=%0d, expected 0/1", strb_err, b_hs);
    end
    @(negedge i_clk);
    n_cmp++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b a cycle later, expected 0/0", o_done, o_busy);
    end
  endtask

  task automatic test_wstall();
    logic [BW-1:0] blk;
    beat_q_t exp;
    for (int i = 0; i < BEATS; i++) blk[i*DW +: DW] = DW'(i);
    exp = model_beats(blk);
    drive_burst(32'h1234_5678, blk, 0, 1, 0, 0, 0, 0, 2'b00);
    foreach (exp[i]) begin
      n_cmp++;
      if (i >= beats_q.size() || beats_q[i] !== exp[i] || lasts_q[i] !== (i == exp.size() - 1)) begin
        n_bad++;
        $display("FAIL wstall_beat[%0d]: got %h last=%b, expected %h last=%b",
                 i, beats_q[i], lasts_q[i], exp[i], (i == exp.size() - 1));
      end
    end
    n_cmp++;
    if (stab_err !== 0) begin
      n_bad++;
      $display("FAIL wstall_stable: got %0d unstable stall cycles, expected 0", stab_err);
    end
    n_cmp++;
    if (done_cyc !== 2 * BEATS + 3) begin
      n_bad++;
      $display("FAIL wstall_latency: got done at cycle %0d, expected %0d", done_cyc, 2 * BEATS + 3);
    end
    @(negedge i_clk);
  endtask

  task automatic test_aw_wait();
    logic [BW-1:0] blk;
    logic [AW-1:0] a;
    beat_q_t exp;
    blk = rand_block(); a = $urandom(); exp = model_beats(blk);
    drive_burst(a, blk, 5, 0, 0, 1, 0, 0, 2'b00);
    n_cmp++;
    if (w_before_aw !== 0 || stab_err !== 0) begin
      n_bad++;
      $display("FAIL awwait_order: got w_before_aw=%0d stab_err=%0d, expected 0/0", w_before_aw, stab_err);
    end
    n_cmp++;
    if (b_hs !== 1 || done_cyc !== BEATS + 3 + 5) begin
      n_bad++;
      $display("FAIL awwait_done: got b_hs=%0d done at %0d, expected 1/%0d", b_hs, done_cyc, BEATS + 8);
    end
    n_cmp++;
    if (cap_awaddr !== model_addr(a) || o_error !== 1'b0) begin
      n_bad++;
      $display("FAIL awwait_addr_err: got awaddr=%h err=%b, expected %h/0", cap_awaddr, o_error, model_addr(a));
    end
    foreach (exp[i]) begin
      n_cmp++;
      if (i >= beats_q.size() || beats_q[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL awwait_beat[%0d]: got %h, expected %h", i, beats_q[i], exp[i]);
      end
    end
    @(negedge i_clk);
  endtask

  task automatic test_mid_start();
    logic [BW-1:0] blk;
    logic [AW-1:0] a;
    beat_q_t exp;
    blk = rand_block(); a = $urandom(); exp = model_beats(blk);
    drive_burst(a, blk, 0, 0, 0, 0, 4, 0, 2'b00);
    n_cmp++;
    if (aw_hs !== 1 || cap_awaddr !== model_addr(a) || done_cyc !== BEATS + 3) begin
      n_bad++;
      $display("FAIL midstart_aw: got aw_hs=%0d awaddr=%h done=%0d, expected 1/%h/%0d",
               aw_hs, cap_awaddr, done_cyc, model_addr(a), BEATS + 3);
    end
    foreach (exp[i]) begin
      n_cmp++;
      if (i >= beats_q.size() || beats_q[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL midstart_beat[%0d]: got %h, expected %h", i, beats_q[i], exp[i]);
      end
    end
    @(negedge i_clk);
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midstart_queued: got busy=%b after completion, expected 0", o_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] blk_a, blk_b;
    logic [AW-1:0] a, b;
    beat_q_t exp;
    blk_a = rand_block(); blk_b = rand_block(); a = $urandom(); b = $urandom();
    drive_burst(a, blk_a, 0, 0, 0, 0, 0, 0, 2'b00);
    n_cmp++;
    if (done_cyc !== BEATS + 3) begin
      n_bad++;
      $display("FAIL b2b_first_done: got %0d, expected %0d", done_cyc, BEATS + 3);
    end
    exp = model_beats(blk_b);
    drive_burst(b, blk_b, 0, 0, 0, 0, 0, 0, 2'b00);
    n_cmp++;
    if (first_awvalid !== 1'b1 || cap_awaddr !== model_addr(b)) begin
      n_bad++;
      $display("FAIL b2b_second_aw: got awvalid=%b awaddr=%h, expected 1/%h",
               first_awvalid, cap_awaddr, model_addr(b));
    end
    foreach (exp[i]) begin
      n_cmp++;
      if (i >= beats_q.size() || beats_q[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL b2b_beat[%0d]: got %h, expected %h", i, beats_q[i], exp[i]);
      end
    end
    @(negedge i_clk);
  endtask

  task automatic test_abort();
    logic [BW-1:0] blk;
    beat_q_t exp;
    blk = rand_block(); exp = model_beats(blk);
    drive_burst(32'h0000_1000, blk, 0, 0, 0, 0, 0, 8, 2'b00);
    n_cmp++;
    if (rst_snap !== 6'b0 || beats_q.size() !== 8) begin
      n_bad++;
      $display("FAIL abort_outputs: got busy/awv/wv/br/done/last=%b after %0d beats, expected 000000 after 8",
               rst_snap, beats_q.size());
    end
    @(negedge i_clk);
    i_arst = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_release: got busy=%b done=%b, expected 0/0", o_busy, o_done);
    end
    drive_burst(32'h0000_2000, blk, 0, 0, 0, 0, 0, 0, 2'b00);
    foreach (exp[i]) begin
      n_cmp++;
      if (i >= beats_q.size() || beats_q[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL abort_restart_beat[%0d]: got %h, expected %h", i, beats_q[i], exp[i]);
      end
    end
    @(negedge i_clk);
  endtask

  task automatic test_bresp();
    logic [BW-1:0] blk;
    blk = rand_block();
    drive_burst($urandom(), blk, 0, 0, 1, 0, 0, 0, 2'b10);
    n_cmp++;
    if (o_error !== EXP_ERR) begin
      n_bad++;
      $display("FAIL bresp_set: got error=%b, expected %b", o_error, EXP_ERR);
    end
    repeat (3) @(negedge i_clk);
    n_cmp++;
    if (o_error !== EXP_ERR) begin
      n_bad++;
      $display("FAIL bresp_sticky: got error=%b, expected %b", o_error, EXP_ERR);
    end
    drive_burst($urandom(), blk, 0, 0, 0, 0, 0, 0, 2'b00);
    n_cmp++;
    if (err_c1 !== 1'b0 || o_error !== 1'b0) begin
      n_bad++;
      $display("FAIL bresp_clear: got error=%b after start, %b at done, expected 0/0", err_c1, o_error);
    end
    @(negedge i_clk);
  endtask

  task automatic test_random();
    logic [BW-1:0] blk;
    logic [AW-1:0] a;
    beat_q_t exp;
    for (int n = 0; n < 6; n++) begin
      blk = rand_block(); a = $urandom(); exp = model_beats(blk);
      drive_burst(a, blk, $urandom_range(0, 3), 2, $urandom_range(0, 3), 0, 0, 0, 2'b00);
      n_cmp++;
      if (cap_awaddr !== model_addr(a) || done_cyc < BEATS + 3 || stab_err !== 0 || w_before_aw !== 0) begin
        n_bad++;
        $display("FAIL random%0d_ctrl: got awaddr=%h done=%0d stab=%0d early_w=%0d, expected %h/>=%0d/0/0",
                 n, cap_awaddr, done_cyc, stab_err, w_before_aw, model_addr(a), BEATS + 3);
      end
      foreach (exp[i]) begin
        n_cmp++;
        if (i >= beats_q.size() || beats_q[i] !== exp[i] || lasts_q[i] !== (i == exp.size() - 1)) begin
          n_bad++;
          $display("FAIL random%0d_beat[%0d]: got %h last=%b, expected %h last=%b",
                   n, i, beats_q[i], lasts_q[i], exp[i], (i == exp.size() - 1));
        end
      end
      repeat ($urandom_range(1, 3)) @(negedge i_clk);
    end
  endtask

  initial begin
    i_arst = 1'b1; i_start = 1'b0; i_addr = '0; i_data_block = '0;
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
    repeat (3) @(negedge i_clk);
    test_reset();
    test_basic();
    test_wstall();
    test_aw_wait();
    test_mid_start();
    test_back_to_back();
    test_abort();
    test_bresp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1);
  end

endmodule
